// File: rtl/crack_result_collector.sv
// Picks the first RC4 search core to crack and stops all cores. Latches the winning
// key, copies the winner's decrypted message into the result RAM and drives the status LEDs.
module crack_result_collector #(
    parameter int CORE_NUMBER    = 4,
    parameter int MESSAGE_LENGTH = 32,
    parameter int RD_WAIT        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_NUMBER-1:0]          core_cracked,
    input  logic [CORE_NUMBER-1:0]          core_failed,
    input  logic [24*CORE_NUMBER-1:0]       core_key,
    input  logic [8*CORE_NUMBER-1:0]        core_q_d,
    output logic                            done,
    output logic [4:0]                      core_address_d,
    output logic                            wren_o,
    output logic [4:0]                      address_o,
    output logic [7:0]                      data_o,
    output logic [23:0]                     final_secret_key,
    output logic [$clog2(CORE_NUMBER)-1:0]  winner,
    output logic                            copy_done,
    output logic                            cracked,
    output logic                            failed,
    output logic                            not_done
);

    localparam int WW     = $clog2(CORE_NUMBER);
    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);
    localparam logic [4:0]        K_LAST    = 5'(MESSAGE_LENGTH - 1);

    typedef enum logic [2:0] {
        SEARCH,
        COPY_ADDR,
        COPY_WAIT,
        COPY_WRITE,
        CRACKED,
        FAILED
    } state_t;

    state_t              state, state_n;
    logic [4:0]          k, k_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic                done_n, wren_n, copy_done_n, cracked_n, failed_n, not_done_n;
    logic [4:0]          core_address_n, address_n;
    logic [7:0]          data_n;
    logic [23:0]         key_n;
    logic [WW-1:0]       winner_n;
    logic [WW-1:0]       lowest;

    // Lowest-index cracked core wins a simultaneous crack.
    always_comb begin
        lowest = '0;
        for (int i = CORE_NUMBER - 1; i >= 0; i--) begin
            if (core_cracked[i]) begin
                lowest = WW'(i);
            end
        end
    end

    always_comb begin
        state_n        = state;
        k_n            = k;
        wait_n         = wait_cnt;
        done_n         = done;
        wren_n         = 1'b0;
        core_address_n = core_address_d;
        address_n      = address_o;
        data_n         = data_o;
        key_n          = final_secret_key;
        winner_n       = winner;
        copy_done_n    = copy_done;
        cracked_n      = cracked;
        failed_n       = failed;
        not_done_n     = not_done;

        case (state)
            SEARCH: begin
                if (|core_cracked) begin
                    winner_n = lowest;
                    key_n    = core_key[24*lowest +: 24];
                    done_n   = 1'b1;
                    k_n      = '0;
                    state_n  = COPY_ADDR;
                end else if (&core_failed) begin
                    state_n = FAILED;
                end
            end
            COPY_ADDR: begin
                core_address_n = k;
                wait_n         = '0;
                state_n        = COPY_WAIT;
            end
            COPY_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_n = COPY_WRITE;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            COPY_WRITE: begin
                address_n = k;
                data_n    = core_q_d[8*winner +: 8];
                wren_n    = 1'b1;
                if (k == K_LAST) begin
                    state_n = CRACKED;
                end else begin
                    k_n     = k + 5'd1;
                    state_n = COPY_ADDR;
                end
            end
            CRACKED: begin
                copy_done_n = 1'b1;
                cracked_n   = 1'b1;
                not_done_n  = 1'b0;
            end
            FAILED: begin
                failed_n   = 1'b1;
                not_done_n = 1'b0;
                done_n     = 1'b0;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= SEARCH;
            k                <= '0;
            wait_cnt         <= '0;
            done             <= 1'b0;
            wren_o           <= 1'b0;
            core_address_d   <= '0;
            address_o        <= '0;
            data_o           <= '0;
            final_secret_key <= '0;
            winner           <= '0;
            copy_done        <= 1'b0;
            cracked          <= 1'b0;
            failed           <= 1'b0;
            not_done         <= 1'b1;
        end else begin
            state            <= state_n;
            k                <= k_n;
            wait_cnt         <= wait_n;
            done             <= done_n;
            wren_o           <= wren_n;
            core_address_d   <= core_address_n;
            address_o        <= address_n;
            data_o           <= data_n;
            final_secret_key <= key_n;
            winner           <= winner_n;
            copy_done        <= copy_done_n;
            cracked          <= cracked_n;
            failed           <= failed_n;
            not_done         <= not_done_n;
        end
    end

endmodule
